// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_bank Wishbone GPIO block: register indices and bus width.
package gpio_pkg;

  localparam int unsigned GPIO_BUS_W = 32;

  typedef enum logic [2:0] {
    GPIO_REG_IN   = 3'd0,
    GPIO_REG_OUT  = 3'd1,
    GPIO_REG_DIR  = 3'd2,
    GPIO_REG_IE   = 3'd3,
    GPIO_REG_RISE = 3'd4,
    GPIO_REG_FALL = 3'd5,
    GPIO_REG_PEND = 3'd6,
    GPIO_REG_RSVD = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce.sv
// One-bit input filter: q follows d only after d has differed from q for CYCLES consecutive cycles.
module gpio_debounce #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (d != q_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        q_d = d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gpio_bank.sv
// N-bit Wishbone GPIO bank with direction, 2-FF sync, edge detect, W1C pending and level IRQ.
// Optional per-bit input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [GPIO_BUS_W-1:0] wb_adr_i,
  input  logic [GPIO_BUS_W-1:0] wb_dat_i,
  output logic [GPIO_BUS_W-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [WIDTH-1:0]      gpio_i,
  output logic [WIDTH-1:0]      gpio_o,
  output logic [WIDTH-1:0]      gpio_oe,
  output logic                  irq
);

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ie_q, ie_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, fd_q, fd_d;
  logic [WIDTH-1:0] filt, ev, w1c, wdata;
  logic [GPIO_BUS_W-1:0] dat_q, dat_d, rdata;
  logic      ack_q, ack_d, irq_q, irq_d;
  logic      access, wr;
  gpio_reg_e reg_idx;

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
    gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .d   (s2_q[i]),
      .q   (filt[i])
    );
  end
`else
  assign filt = s2_q;
`endif

  always_comb begin
    access  = wb_stb_i & wb_cyc_i & ~ack_q;
    wr      = access & wb_we_i;
    reg_idx = gpio_reg_e'(wb_adr_i[4:2]);
    wdata   = wb_dat_i[WIDTH-1:0];

    // Driven bits are sampled from the output register so edges on outputs are seen too.
    s1_d = (dir_q & out_q) | (~dir_q & gpio_i);
    s2_d = s1_q;
    fd_d = filt;
    ev   = (filt & ~fd_q & rise_q) | (~filt & fd_q & fall_q);

    out_d  = out_q;
    dir_d  = dir_q;
    ie_d   = ie_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr) begin
      case (reg_idx)
        GPIO_REG_OUT:  out_d  = wdata;
        GPIO_REG_DIR:  dir_d  = wdata;
        GPIO_REG_IE:   ie_d   = wdata;
        GPIO_REG_RISE: rise_d = wdata;
        GPIO_REG_FALL: fall_d = wdata;
        GPIO_REG_PEND: w1c    = wdata;
        default:       ;
      endcase
    end
    pend_d = ev | (pend_q & ~w1c);
    irq_d  = |(pend_q & ie_q);

    rdata = '0;
    case (reg_idx)
      GPIO_REG_IN:   rdata[WIDTH-1:0] = filt;
      GPIO_REG_OUT:  rdata[WIDTH-1:0] = out_q;
      GPIO_REG_DIR:  rdata[WIDTH-1:0] = dir_q;
      GPIO_REG_IE:   rdata[WIDTH-1:0] = ie_q;
      GPIO_REG_RISE: rdata[WIDTH-1:0] = rise_q;
      GPIO_REG_FALL: rdata[WIDTH-1:0] = fall_q;
      GPIO_REG_PEND: rdata[WIDTH-1:0] = pend_q;
      default:       rdata = '0;
    endcase

    ack_d = access;
    dat_d = (access && !wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      ie_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      fd_q   <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      ie_q   <= ie_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      fd_q   <= fd_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
    end
  end

  assign gpio_o   = out_q;
  assign gpio_oe  = dir_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = irq_q;

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, DEBOUNCE_CYCLES[0]};

endmodule
